// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// A shadow pipeline of destination-register tags (EX plus FWD_STAGES later
// stages) drives the forwarding selects, load-use stalls, redirect flushes
// and memory-wait freezes. It also keeps saturating hazard event counters.
// FWD_STAGES must be at least LOAD_LAT+1 so a load always reaches a forwarding stage.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_reg,
  input  logic                  id_is_load,
  input  logic                  ex_redirect,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  freeze,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
);

  typedef enum logic [1:0] {M_NORMAL, M_HAZARD, M_REDIRECT, M_FREEZE} mode_t;

  // Destination tags for every tracked stage; index 0 is EX.
  logic                  r_v   [0:FWD_STAGES];
  logic                  r_wr  [0:FWD_STAGES];
  logic [REG_ADDR_W-1:0] r_reg [0:FWD_STAGES];
  logic                  r_ld  [0:FWD_STAGES];
  // Source fields are only ever consulted in EX, so only stage 0 keeps them.
  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;
  logic                  r_ex_rs_u;
  logic                  r_ex_rt_u;

  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic [CNT_W-1:0]      r_freeze_cnt;

  logic                  w_ld_hit;
  logic                  w_hazard;
  logic [SEL_W-1:0]      w_sel_a;
  logic [SEL_W-1:0]      w_sel_b;
  mode_t                 w_mode;
  logic                  w_take;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Register 0 is hard-wired zero and never produces a forwarding match.
  function automatic logic match(input logic v, input logic wr,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] src);
    return v & wr & (rd == src) & (|src);
  endfunction

  // Load-use detection: the ID reader depends on a load too young to forward.
  always_comb begin
    w_ld_hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (r_ld[i] &&
          ((id_rs_used && match(r_v[i], r_wr[i], r_reg[i], id_rs)) ||
           (id_rt_used && match(r_v[i], r_wr[i], r_reg[i], id_rt))))
        w_ld_hit = 1'b1;
    end
    w_hazard = id_valid & w_ld_hit;
  end

  // Forwarding select: youngest matching writer wins; an unready load blocks older ones.
  always_comb begin
    logic found_a;
    logic found_b;
    found_a = 1'b0;
    found_b = 1'b0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 1; i <= FWD_STAGES; i++) begin
      if (!found_a && r_ex_rs_u && match(r_v[i], r_wr[i], r_reg[i], r_ex_rs)) begin
        found_a = 1'b1;
        w_sel_a = (r_ld[i] && (i < LOAD_LAT + 1)) ? '0 : SEL_W'(i);
      end
      if (!found_b && r_ex_rt_u && match(r_v[i], r_wr[i], r_reg[i], r_ex_rt)) begin
        found_b = 1'b1;
        w_sel_b = (r_ld[i] && (i < LOAD_LAT + 1)) ? '0 : SEL_W'(i);
      end
    end
  end

  // Cycle mode by priority: memory wait, then redirect, then load-use stall.
  always_comb begin
    w_mode = M_NORMAL;
    if (!mem_ready)
      w_mode = M_FREEZE;
    else if (ex_redirect)
      w_mode = M_REDIRECT;
    else if (w_hazard)
      w_mode = M_HAZARD;
  end

  // Pipeline control outputs; reset forces a flushed, non-advancing front end.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    case (w_mode)
      M_FREEZE: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        freeze  = 1'b1;
      end
      M_REDIRECT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      M_HAZARD: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
    fwd_sel_a = w_sel_a;
    fwd_sel_b = w_sel_b;
    if (reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      freeze      = 1'b0;
      fwd_sel_a   = '0;
      fwd_sel_b   = '0;
    end
  end

  // The ID instruction enters EX only on a normal cycle (never as a bubble).
  assign w_take = id_valid & (w_mode == M_NORMAL);

  // Shadow pipeline: shift one stage per unfrozen edge, oldest entry drops off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= FWD_STAGES; i++) begin
        r_v[i]   <= 1'b0;
        r_wr[i]  <= 1'b0;
        r_reg[i] <= '0;
        r_ld[i]  <= 1'b0;
      end
      r_ex_rs   <= '0;
      r_ex_rt   <= '0;
      r_ex_rs_u <= 1'b0;
      r_ex_rt_u <= 1'b0;
    end else if (w_mode != M_FREEZE) begin
      for (int i = FWD_STAGES; i > 0; i--) begin
        r_v[i]   <= r_v[i-1];
        r_wr[i]  <= r_wr[i-1];
        r_reg[i] <= r_reg[i-1];
        r_ld[i]  <= r_ld[i-1];
      end
      r_v[0]    <= w_take;
      r_wr[0]   <= w_take & id_wr_en;
      r_reg[0]  <= w_take ? id_wr_reg : '0;
      r_ld[0]   <= w_take & id_is_load;
      r_ex_rs   <= w_take ? id_rs : '0;
      r_ex_rt   <= w_take ? id_rt : '0;
      r_ex_rs_u <= w_take & id_rs_used;
      r_ex_rt_u <= w_take & id_rt_used;
    end
  end

  // Event counters, one increment per cycle of the matching mode, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      case (w_mode)
        M_FREEZE:   r_freeze_cnt <= sat_inc(r_freeze_cnt);
        M_REDIRECT: r_flush_cnt  <= sat_inc(r_flush_cnt);
        M_HAZARD:   r_stall_cnt  <= sat_inc(r_stall_cnt);
        default: ;
      endcase
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign freeze_cnt = r_freeze_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a default instance (LOAD_LAT=1, 32-bit counters)
// and a LOAD_LAT=2 instance with 2-bit counters share the same stimulus.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       ex_redirect, mem_ready;

  logic        pc_we1, ifid_we1, ifid_flush1, idex_bubble1, freeze1;
  logic [1:0]  sel_a1, sel_b1;
  logic [31:0] stall_cnt1, flush_cnt1, freeze_cnt1;
  logic        pc_we2, ifid_we2, ifid_flush2, idex_bubble2, freeze2;
  logic [1:0]  sel_a2, sel_b2;
  logic [1:0]  stall_cnt2, flush_cnt2, freeze_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic v; logic [4:0] rs; logic [4:0] rt; logic rsu; logic rtu;
    logic wr; logic [4:0] wd; logic ld; logic redir; logic rdy;
  } stim_t;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, freeze}
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] REDIR = 5'b11110;
  localparam logic [4:0] FRZ   = 5'b00001;
  localparam logic [4:0] RSTV  = 5'b00110;

  logic [8:0] sb[$];

  pipe_hazard_unit #(.REG_ADDR_W(5), .FWD_STAGES(3), .LOAD_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_ready(mem_ready), .pc_we(pc_we1), .ifid_we(ifid_we1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .freeze(freeze1), .fwd_sel_a(sel_a1), .fwd_sel_b(sel_b1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .freeze_cnt(freeze_cnt1));

  pipe_hazard_unit #(.REG_ADDR_W(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_ready(mem_ready), .pc_we(pc_we2), .ifid_we(ifid_we2), .ifid_flush(ifid_flush2),
    .idex_bubble(idex_bubble2), .freeze(freeze2), .fwd_sel_a(sel_a2), .fwd_sel_b(sel_b2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .freeze_cnt(freeze_cnt2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic rsu, input logic rtu, input logic wr,
                               input logic [4:0] wd, input logic ld, input logic redir,
                               input logic rdy);
    stim_t s;
    s = '{v, rs, rt, rsu, rtu, wr, wd, ld, redir, rdy};
    return s;
  endfunction

  function automatic logic [8:0] obs1();
    return {pc_we1, ifid_we1, ifid_flush1, idex_bubble1, freeze1, sel_a1, sel_b1};
  endfunction

  function automatic logic [8:0] obs2();
    return {pc_we2, ifid_we2, ifid_flush2, idex_bubble2, freeze2, sel_a2, sel_b2};
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_rs_used = s.rsu; id_rt_used = s.rtu;
    id_wr_en = s.wr; id_wr_reg = s.wd; id_is_load = s.ld;
    ex_redirect = s.redir; mem_ready = s.rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] got, want;
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back({RSTV, 4'b0000});
    @(negedge clk);
    got = obs1(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL reset_ctrl1 got %b want %b", got, want); end
    sb.push_back({RSTV, 4'b0000});
    got = obs2(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL reset_ctrl2 got %b want %b", got, want); end
    n_chk++;
    if ({stall_cnt1, flush_cnt1, freeze_cnt1} !== 96'd0) begin
      n_fail++; $display("FAIL reset_cnt1 got %0d/%0d/%0d want 0/0/0", stall_cnt1, flush_cnt1, freeze_cnt1);
    end
    n_chk++;
    if ({stall_cnt2, flush_cnt2, freeze_cnt2} !== 6'd0) begin
      n_fail++; $display("FAIL reset_cnt2 got %0d/%0d/%0d want 0/0/0", stall_cnt2, flush_cnt2, freeze_cnt2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    do_reset();
    st.push_back(mk(1, 1, 0, 1, 0, 1, 2, 1, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});  // lw r2
    st.push_back(mk(1, 2, 4, 1, 1, 1, 3, 0, 0, 1)); ex.push_back({STALL, 2'd0, 2'd0}); // add r3,r2,r4
    st.push_back(mk(1, 2, 4, 1, 1, 1, 3, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back({NORM, 2'd2, 2'd0});
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs1(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL load_use[%0d] got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    n_chk++;
    if (stall_cnt1 !== 32'd1) begin n_fail++; $display("FAIL load_use_stall_cnt got %0d want 1", stall_cnt1); end
  endtask

  task automatic test_forward();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    do_reset();
    st.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0}); // add r5
    st.push_back(mk(1, 5, 5, 1, 1, 1, 6, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0}); // sub r6,r5,r5
    st.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 1)); ex.push_back({NORM, 2'd1, 2'd1}); // add r5 (sub in EX)
    st.push_back(mk(1, 5, 0, 1, 1, 1, 8, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0}); // or r8,r5,r0
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back({NORM, 2'd1, 2'd0}); // r5 at 1 and 3
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs1(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL forward[%0d] got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    n_chk++;
    if (stall_cnt1 !== 32'd0) begin n_fail++; $display("FAIL forward_stall_cnt got %0d want 0", stall_cnt1); end
  endtask

  task automatic test_load_lat2();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    do_reset();
    st.push_back(mk(1, 1, 0, 1, 0, 1, 7, 1, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});  // lw r7
    st.push_back(mk(1, 7, 0, 1, 0, 1, 9, 0, 0, 1)); ex.push_back({STALL, 2'd0, 2'd0}); // use r7
    st.push_back(mk(1, 7, 0, 1, 0, 1, 9, 0, 0, 1)); ex.push_back({STALL, 2'd0, 2'd0});
    st.push_back(mk(1, 7, 0, 1, 0, 1, 9, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back({NORM, 2'd3, 2'd0});
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs2(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL load_lat2[%0d] got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    n_chk++;
    if (stall_cnt2 !== 2'd2) begin n_fail++; $display("FAIL load_lat2_stall_cnt got %0d want 2", stall_cnt2); end
  endtask

  task automatic test_redirect();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    do_reset();
    st.push_back(mk(1, 1, 0, 1, 0, 1, 2, 1, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});  // lw r2
    st.push_back(mk(1, 2, 4, 1, 1, 1, 3, 0, 1, 1)); ex.push_back({REDIR, 2'd0, 2'd0}); // use + redirect
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs1(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL redirect[%0d] got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    n_chk++;
    if (stall_cnt1 !== 32'd0) begin n_fail++; $display("FAIL redirect_stall_cnt got %0d want 0", stall_cnt1); end
    n_chk++;
    if (flush_cnt1 !== 32'd1) begin n_fail++; $display("FAIL redirect_flush_cnt got %0d want 1", flush_cnt1); end
  endtask

  task automatic test_freeze();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    do_reset();
    st.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});  // add r5
    st.push_back(mk(1, 5, 5, 1, 1, 1, 6, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});  // sub r6,r5,r5
    for (int j = 0; j < 3; j++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); ex.push_back({FRZ, 2'd1, 2'd1});
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); ex.push_back({REDIR, 2'd1, 2'd1});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0});
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs1(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL freeze[%0d] got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    n_chk++;
    if (freeze_cnt1 !== 32'd3) begin n_fail++; $display("FAIL freeze_cnt got %0d want 3", freeze_cnt1); end
    n_chk++;
    if (flush_cnt1 !== 32'd1) begin n_fail++; $display("FAIL freeze_flush_cnt got %0d want 1", flush_cnt1); end
  endtask

  task automatic test_reg0_and_reset();
    stim_t st[$]; logic [8:0] ex[$]; logic [8:0] got, want;
    do_reset();
    st.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0}); // add r0
    st.push_back(mk(1, 0, 0, 1, 1, 1, 9, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0}); // read r0
    st.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0}); // add r5
    st.push_back(mk(1, 5, 5, 1, 1, 1, 6, 0, 0, 1)); ex.push_back({NORM, 2'd0, 2'd0}); // sub r6,r5,r5
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back({FRZ, 2'd1, 2'd1});
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back({FRZ, 2'd1, 2'd1});
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs1(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reg0_freeze[%0d] got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    n_chk++;
    if (freeze_cnt1 !== 32'd2) begin n_fail++; $display("FAIL pre_reset_freeze_cnt got %0d want 2", freeze_cnt1); end
    reset = 1'b1;  // asynchronous, mid-cycle, memory still waiting
    sb.push_back({RSTV, 4'b0000});
    #2;
    got = obs1(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL midfreeze_reset_ctrl got %b want %b", got, want); end
    n_chk++;
    if ({stall_cnt1, flush_cnt1, freeze_cnt1} !== 96'd0) begin
      n_fail++; $display("FAIL midfreeze_reset_cnt got %0d/%0d/%0d want 0/0/0", stall_cnt1, flush_cnt1, freeze_cnt1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    sb.push_back({NORM, 2'd0, 2'd0});
    @(negedge clk);
    got = obs1(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL post_reset_ctrl got %b want %b", got, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [8:0] got, want;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); sb.push_back({FRZ, 2'd0, 2'd0});
      @(negedge clk);
      got = obs2(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL sat_freeze[%0d] got %b want %b", k, got, want); end
      @(posedge clk); #1;
    end
    n_chk++;
    if (freeze_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_freeze_cnt2 got %0d want 3", freeze_cnt2); end
    n_chk++;
    if (freeze_cnt1 !== 32'd5) begin n_fail++; $display("FAIL sat_freeze_cnt1 got %0d want 5", freeze_cnt1); end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  initial begin
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    test_reset();
    test_load_use();
    test_forward();
    test_load_lat2();
    test_redirect();
    test_freeze();
    test_reg0_and_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
